// File: rtl/rs232_flow_fifo.sv
// Ready/valid FIFO between rs232 rx and tx with hysteretic almostfull (CTS) and sticky overflow; RS232_FIFO_DROPCNT_EN adds a drop counter.
// Latency: a word written at edge N is on odata after edge N and can be consumed at edge N+1.
// Backpressure: iready/ovalid decode registered level only; a read while full reopens iready one cycle later.
module rs232_flow_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int AFULL_HI   = 6,
    parameter int AFULL_LO   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      idata,
    input  logic                  ivalid,
    output logic                  iready,
    output logic [WIDTH-1:0]      odata,
    output logic                  ovalid,
    input  logic                  oready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almostfull,
    output logic                  overflow,
    input  logic                  clear_overflow
`ifdef RS232_FIFO_DROPCNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] HI_L    = LW'(AFULL_HI);
    localparam logic [LW-1:0] LO_L    = LW'(AFULL_LO);

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8 || AFULL_LO >= AFULL_HI || AFULL_HI > DEPTH) begin : g_bad_params
        $error("rs232_flow_fifo: need 1<=DEPTH_LOG2<=8 and AFULL_LO < AFULL_HI <= DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;
    logic             wr_fire, rd_fire, drop;

    assign iready     = (level_q < DEPTH_L);
    assign ovalid     = (level_q != '0);
    assign odata      = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign almostfull = afull_q;
    assign overflow   = ovf_q;

    assign wr_fire = ivalid & iready;
    assign rd_fire = ovalid & oready;
    assign drop    = ivalid & ~iready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q] = idata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(wr_fire) - LW'(rd_fire);

        // Hysteresis band: between LO and HI the request keeps its last value.
        afull_d = afull_q;
        if (level_d >= HI_L) begin
            afull_d = 1'b1;
        end else if (level_d <= LO_L) begin
            afull_d = 1'b0;
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    // Storage is not reset; emptiness is tracked entirely by level.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef RS232_FIFO_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_overflow) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rs232_flow_fifo.sv
// Scoreboard bench for rs232_flow_fifo (default parameters); drop counter scenario runs when RS232_FIFO_DROPCNT_EN is defined.
module tb_rs232_flow_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  idata;
    logic        ivalid;
    logic        iready;
    logic [7:0]  odata;
    logic        ovalid;
    logic        oready;
    logic [3:0]  level;
    logic        almostfull;
    logic        overflow;
    logic        clear_overflow;
`ifdef RS232_FIFO_DROPCNT_EN
    logic [15:0] drop_count;
`endif

    rs232_flow_fifo #(.WIDTH(8), .DEPTH_LOG2(3), .AFULL_HI(6), .AFULL_LO(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .idata          (idata),
        .ivalid         (ivalid),
        .iready         (iready),
        .odata          (odata),
        .ovalid         (ovalid),
        .oready         (oready),
        .level          (level),
        .almostfull     (almostfull),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef RS232_FIFO_DROPCNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic       rd_fired;
    logic [7:0] rd_exp;
    logic [7:0] obs_odata;
    logic       obs_iready;

    // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
    task automatic drive_cycle(input logic wv, input logic [7:0] wd, input logic rr, input logic clr);
        logic wf;
        logic rf;
        ivalid         = wv;
        idata          = wd;
        oready         = rr;
        clear_overflow = clr;
        wf = wv && (sb.size() < 8);
        rf = rr && (sb.size() > 0);
        rd_fired = rf;
        rd_exp   = rf ? sb[0] : 8'h00;
        #1;
        obs_odata  = odata;
        obs_iready = iready;
        @(posedge clock);
        #1;
        if (rf) void'(sb.pop_front());
        if (wf) sb.push_back(wd);
        ivalid         = 1'b0;
        oready         = 1'b0;
        clear_overflow = 1'b0;
    endtask

    task automatic do_reset(input logic busy);
        reset  = 1'b1;
        ivalid = busy;
        idata  = 8'h77;
        oready = busy;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        ivalid = 1'b0;
        oready = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b exp 0", ovalid); end
        checks++; if (iready !== 1'b1) begin errors++; $display("FAIL reset_iready got %b exp 1", iready); end
        checks++; if (almostfull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", almostfull); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_latency;
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL lat_ovalid got %b exp 1", ovalid); end
        checks++; if (odata !== 8'hA5) begin errors++; $display("FAIL lat_odata got %h exp a5", odata); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL lat_level got %0d exp 1", level); end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            checks++; if (odata !== 8'hA5) begin errors++; $display("FAIL hold_odata cyc %0d got %h exp a5", i, odata); end
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (!rd_fired || obs_odata !== rd_exp) begin errors++; $display("FAIL lat_read got %h exp %h", obs_odata, rd_exp); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL lat_empty got %b exp 0", ovalid); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level got %0d exp 8", level); end
        checks++; if (iready !== 1'b0) begin errors++; $display("FAIL full_iready got %b exp 0", iready); end
        drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", level); end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            if (i == 0) begin
                checks++; if (obs_iready !== 1'b0) begin errors++; $display("FAIL full_read_iready got %b exp 0", obs_iready); end
                checks++; if (iready !== 1'b1) begin errors++; $display("FAIL after_read_iready got %b exp 1", iready); end
            end
            checks++; if (!rd_fired || obs_odata !== rd_exp || rd_exp !== 8'(i)) begin
                errors++; $display("FAIL drain_order idx %0d got %h exp %h", i, obs_odata, 8'(i));
            end
        end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", ovalid); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_almostfull;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
            checks++; if (almostfull !== (i == 5)) begin errors++; $display("FAIL afull_fill lvl %0d got %b exp %b", i + 1, almostfull, i == 5); end
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (almostfull !== 1'b1) begin errors++; $display("FAIL afull_at5_down got %b exp 1", almostfull); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (almostfull !== 1'b0) begin errors++; $display("FAIL afull_at4 got %b exp 0", almostfull); end
        drive_cycle(1'b1, 8'h50, 1'b0, 1'b0);
        checks++; if (almostfull !== 1'b0 || level !== 4'd5) begin errors++; $display("FAIL afull_at5_up got %b/%0d exp 0/5", almostfull, level); end
        while (sb.size() > 0) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (obs_odata !== rd_exp) begin errors++; $display("FAIL afull_drain got %h exp %h", obs_odata, rd_exp); end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 8'h13 + 8'(i), 1'b1, 1'b0);
            checks++; if (level !== 4'd3 || obs_iready !== 1'b1) begin errors++; $display("FAIL b2b_level cyc %0d got %0d/%b exp 3/1", i, level, obs_iready); end
            checks++; if (obs_odata !== rd_exp || rd_exp !== 8'h10 + 8'(i)) begin errors++; $display("FAIL b2b_order cyc %0d got %h exp %h", i, obs_odata, 8'h10 + 8'(i)); end
        end
        while (sb.size() > 0) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (obs_odata !== rd_exp) begin errors++; $display("FAIL b2b_drain got %h exp %h", obs_odata, rd_exp); end
        end
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (level !== 4'd5 || overflow !== 1'b1) begin errors++; $display("FAIL pre_reset got %0d/%b exp 5/1", level, overflow); end
        do_reset(1'b1);
        checks++; if (level !== 4'd0 || ovalid !== 1'b0 || iready !== 1'b1) begin
            errors++; $display("FAIL mid_reset lvl/ovalid/iready got %0d/%b/%b exp 0/0/1", level, ovalid, iready);
        end
        checks++; if (almostfull !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_reset flags got %b/%b exp 0/0", almostfull, overflow); end
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", overflow); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (obs_odata !== 8'h70) begin errors++; $display("FAIL post_reset_head got %h exp 70", obs_odata); end
        do_reset(1'b0);
    endtask

`ifdef RS232_FIFO_DROPCNT_EN
    task automatic test_drop_count;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL drop_3 got %0d exp 3", drop_count); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_clear got %0d exp 0", drop_count); end
        drive_cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_clear_load got %0d exp 1", drop_count); end
        for (int i = 0; i < 70000; i++) drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_sat got %h exp ffff", drop_count); end
        do_reset(1'b0);
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_reset got %0d exp 0", drop_count); end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        ivalid         = 1'b0;
        idata          = 8'h00;
        oready         = 1'b0;
        clear_overflow = 1'b0;
        test_reset();
        test_latency();
        test_overflow();
        test_almostfull();
        test_back_to_back();
        test_reset_midflight();
`ifdef RS232_FIFO_DROPCNT_EN
        test_drop_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
